// File: rtl/string_serializer_param_if.sv
// Handshake and data bundle between a string source and the serializer.
// The master side supplies the string and Start; the slave side reports progress and drives the line.
interface string_serializer_param_if #(
    parameter int CHAR_W    = 7,
    parameter int MAX_CHARS = 11
);
    logic [MAX_CHARS*CHAR_W-1:0]      StringPOV;
    logic                             Start;
    logic                             Busy;
    logic                             Done;
    logic                             SendBit;
    logic [$clog2(MAX_CHARS+1)-1:0]   CharCount;

    modport master (
        output StringPOV, Start,
        input  Busy, Done, SendBit, CharCount
    );

    modport slave (
        input  StringPOV, Start,
        output Busy, Done, SendBit, CharCount
    );
endinterface

// File: rtl/string_serializer_param.sv
// Latches a packed string and sends each character as a UART-style frame on SendBit,
// stopping at the first null character or after MAX_CHARS characters.
module string_serializer_param #(
    parameter int CHAR_W    = 7,
    parameter int MAX_CHARS = 11,
    parameter int CLK_DIV   = 4,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  logic clk,
    input  logic Reset,
    string_serializer_param_if.slave bus
);

    localparam int FRAME_W = 1 + CHAR_W + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int BAUD_W  = $clog2(CLK_DIV);
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int IDX_W   = $clog2(MAX_CHARS + 1);
    localparam int STR_W   = MAX_CHARS * CHAR_W;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]         state;
    logic [STR_W-1:0]   stringReg;
    logic [IDX_W-1:0]   charIdx;
    logic [BAUD_W-1:0]  baudCnt;
    logic [BIT_W-1:0]   bitCnt;
    logic [FRAME_W-1:0] frameReg;
    logic               sendBit;
    logic               busy;
    logic               done;

    logic [CHAR_W-1:0]  curChar;
    logic               endOfString;
    logic               parityBit;
    logic [FRAME_W-1:0] frameNext;

    // Character selection saturates to null once the index runs off the end of the string.
    always_comb begin
        curChar = '0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            if (charIdx == IDX_W'(i)) begin
                curChar = stringReg[i*CHAR_W +: CHAR_W];
            end
        end
    end

    assign endOfString = (charIdx == IDX_W'(MAX_CHARS)) || (curChar == '0);
    assign parityBit   = (PARITY == 2) ? ~(^curChar) : ^curChar;

    // Frame is stored LSB-first: start bit, data, optional parity, then stop bits (left at 1).
    always_comb begin
        frameNext             = '1;
        frameNext[0]          = 1'b0;
        frameNext[CHAR_W:1]   = curChar;
        if (PARITY != 0) begin
            frameNext[CHAR_W+1] = parityBit;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            stringReg <= '0;
            charIdx   <= '0;
            baudCnt   <= '0;
            bitCnt    <= '0;
            frameReg  <= '1;
            sendBit   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sendBit <= 1'b1;
                    if (bus.Start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    stringReg <= bus.StringPOV;
                    charIdx   <= '0;
                    busy      <= 1'b1;
                    state     <= FETCH;
                end
                FETCH: begin
                    sendBit <= 1'b1;
                    baudCnt <= '0;
                    bitCnt  <= '0;
                    if (endOfString) begin
                        state <= DONE;
                    end else begin
                        frameReg <= frameNext;
                        state    <= SEND;
                    end
                end
                // Each frame bit is presented for CLK_DIV cycles before the frame shifts.
                SEND: begin
                    sendBit <= frameReg[0];
                    if (baudCnt == BAUD_W'(CLK_DIV - 1)) begin
                        baudCnt  <= '0;
                        frameReg <= {1'b1, frameReg[FRAME_W-1:1]};
                        if (bitCnt == BIT_W'(FRAME_W - 1)) begin
                            bitCnt  <= '0;
                            charIdx <= charIdx + IDX_W'(1);
                            state   <= FETCH;
                        end else begin
                            bitCnt <= bitCnt + BIT_W'(1);
                        end
                    end else begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end
                end
                DONE: begin
                    sendBit <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.SendBit   = sendBit;
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.CharCount = charIdx;

endmodule

// File: tb/tb_string_serializer_param.sv
// Drives three serializer configurations with the same strings and compares their line,
// Done, Busy and CharCount against a cycle-indexed model built from the frame rules.
module tb_string_serializer_param;

    localparam int CW   = 7;
    localparam int MC   = 11;
    localparam int CD   = 4;
    localparam int STRW = CW * MC;
    localparam int NCFG = 3;

    int cfgPar  [NCFG] = '{1, 2, 0};
    int cfgStop [NCFG] = '{1, 1, 2};

    logic            clk;
    logic            resetN;
    logic            start;
    logic [STRW-1:0] stringPov;

    int errors = 0;
    int checks = 0;

    bit   expWave [NCFG][$];
    bit   expDone [NCFG][$];
    bit   expBusy [NCFG][$];
    int   expCount[NCFG];
    logic actWave [NCFG][$];
    logic actDone [NCFG][$];
    logic actBusy [NCFG][$];

    string_serializer_param_if #(.CHAR_W(CW), .MAX_CHARS(MC)) bus0 ();
    string_serializer_param_if #(.CHAR_W(CW), .MAX_CHARS(MC)) bus1 ();
    string_serializer_param_if #(.CHAR_W(CW), .MAX_CHARS(MC)) bus2 ();

    assign bus0.Start = start;  assign bus0.StringPOV = stringPov;
    assign bus1.Start = start;  assign bus1.StringPOV = stringPov;
    assign bus2.Start = start;  assign bus2.StringPOV = stringPov;

    logic       sendBitW [NCFG];
    logic       doneW    [NCFG];
    logic       busyW    [NCFG];
    logic [3:0] ccW      [NCFG];

    assign sendBitW[0] = bus0.SendBit; assign doneW[0] = bus0.Done; assign busyW[0] = bus0.Busy; assign ccW[0] = bus0.CharCount;
    assign sendBitW[1] = bus1.SendBit; assign doneW[1] = bus1.Done; assign busyW[1] = bus1.Busy; assign ccW[1] = bus1.CharCount;
    assign sendBitW[2] = bus2.SendBit; assign doneW[2] = bus2.Done; assign busyW[2] = bus2.Busy; assign ccW[2] = bus2.CharCount;

    string_serializer_param #(.CHAR_W(CW), .MAX_CHARS(MC), .CLK_DIV(CD), .PARITY(1), .STOP_BITS(1))
        dut0 (.clk(clk), .Reset(resetN), .bus(bus0));
    string_serializer_param #(.CHAR_W(CW), .MAX_CHARS(MC), .CLK_DIV(CD), .PARITY(2), .STOP_BITS(1))
        dut1 (.clk(clk), .Reset(resetN), .bus(bus1));
    string_serializer_param #(.CHAR_W(CW), .MAX_CHARS(MC), .CLK_DIV(CD), .PARITY(0), .STOP_BITS(2))
        dut2 (.clk(clk), .Reset(resetN), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // First n chars non-zero, char n null, the rest random garbage that must never be sent.
    function automatic logic [STRW-1:0] randString(input int n);
        logic [STRW-1:0] s;
        s = '0;
        for (int c = 0; c < MC; c++) begin
            if (c < n)       s[c*CW +: CW] = CW'($urandom_range(1, 127));
            else if (c == n) s[c*CW +: CW] = '0;
            else             s[c*CW +: CW] = CW'($urandom_range(0, 127));
        end
        return s;
    endfunction

    // Index i of each expected queue is the sample taken just after the (accept edge + 1 + i).
    task automatic buildExpect(input logic [STRW-1:0] s, input int extra);
        bit frameBits[$];
        logic [CW-1:0] ch;
        for (int cfg = 0; cfg < NCFG; cfg++) begin
            expWave[cfg].delete(); expDone[cfg].delete(); expBusy[cfg].delete();
            expCount[cfg] = 0;
            repeat (2) begin expWave[cfg].push_back(1); expDone[cfg].push_back(0); expBusy[cfg].push_back(1); end
            for (int c = 0; c < MC; c++) begin
                ch = s[c*CW +: CW];
                if (ch == 0) break;
                frameBits.delete();
                frameBits.push_back(0);
                for (int b = 0; b < CW; b++) frameBits.push_back(ch[b]);
                if (cfgPar[cfg] == 1) frameBits.push_back(^ch);
                if (cfgPar[cfg] == 2) frameBits.push_back(~(^ch));
                for (int b = 0; b < cfgStop[cfg]; b++) frameBits.push_back(1);
                foreach (frameBits[b]) begin
                    repeat (CD) begin
                        expWave[cfg].push_back(frameBits[b]); expDone[cfg].push_back(0); expBusy[cfg].push_back(1);
                    end
                end
                expWave[cfg].push_back(1); expDone[cfg].push_back(0); expBusy[cfg].push_back(1);
                expCount[cfg]++;
            end
            expWave[cfg].push_back(1); expDone[cfg].push_back(1); expBusy[cfg].push_back(0);
            repeat (extra) begin expWave[cfg].push_back(1); expDone[cfg].push_back(0); expBusy[cfg].push_back(0); end
        end
    endtask

    function automatic logic actBit(input int cfg, input int kind, input int i);
        if (kind == 0) return actWave[cfg][i];
        if (kind == 1) return actDone[cfg][i];
        return actBusy[cfg][i];
    endfunction

    function automatic bit expBit(input int cfg, input int kind, input int i);
        if (kind == 0) return expWave[cfg][i];
        if (kind == 1) return expDone[cfg][i];
        return expBusy[cfg][i];
    endfunction

    function automatic string kindName(input int kind);
        if (kind == 0) return "SendBit";
        if (kind == 1) return "Done";
        return "Busy";
    endfunction

    function automatic int diffAt(input int cfg, input int kind);
        for (int i = 0; i < actWave[cfg].size(); i++) begin
            if (i >= expWave[cfg].size()) return i;
            if (actBit(cfg, kind, i) !== logic'(expBit(cfg, kind, i))) return i;
        end
        return -1;
    endfunction

    task automatic startString(input logic [STRW-1:0] s, input bit hold);
        stringPov = s;
        start     = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic captureRun(input int len, input int pokeAt, input logic [STRW-1:0] pokePov, input bit pokeStart);
        for (int cfg = 0; cfg < NCFG; cfg++) begin
            actWave[cfg].delete(); actDone[cfg].delete(); actBusy[cfg].delete();
        end
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            for (int cfg = 0; cfg < NCFG; cfg++) begin
                actWave[cfg].push_back(sendBitW[cfg]);
                actDone[cfg].push_back(doneW[cfg]);
                actBusy[cfg].push_back(busyW[cfg]);
            end
            if (pokeAt >= 0 && i == pokeAt) begin
                stringPov = pokePov;
                if (pokeStart) start = 1'b1;
            end else if (pokeAt >= 0 && i == pokeAt + 1 && pokeStart) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b1;
        #2 resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int cfg = 0; cfg < NCFG; cfg++) begin
            checks++; if (sendBitW[cfg] !== 1'b1) begin errors++; $display("[TB] FAIL reset cfg%0d SendBit: got %b expected 1", cfg, sendBitW[cfg]); end
            checks++; if (busyW[cfg] !== 1'b0) begin errors++; $display("[TB] FAIL reset cfg%0d Busy: got %b expected 0", cfg, busyW[cfg]); end
            checks++; if (doneW[cfg] !== 1'b0) begin errors++; $display("[TB] FAIL reset cfg%0d Done: got %b expected 0", cfg, doneW[cfg]); end
            checks++; if (ccW[cfg] !== 4'd0) begin errors++; $display("[TB] FAIL reset cfg%0d CharCount: got %0d expected 0", cfg, ccW[cfg]); end
        end
        resetN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_strings();
        logic [STRW-1:0] s;
        int d;
        for (int k = 0; k < 13; k++) begin
            case (k)
                0: begin s = '0; s[0 +: CW] = 7'h41; s[CW +: CW] = 7'h42; end
                1: begin s = '0; s[0 +: CW] = 7'h07; end
                2: s = '1;
                3: s = randString(0);
                4: begin s = randString(2); s[5*CW +: CW] = 7'h55; end
                default: s = randString($urandom_range(0, MC));
            endcase
            buildExpect(s, 2);
            startString(s, 0);
            captureRun(expWave[0].size(), -1, '0, 0);
            for (int cfg = 0; cfg < NCFG; cfg++) begin
                for (int kind = 0; kind < 3; kind++) begin
                    d = diffAt(cfg, kind);
                    checks++;
                    if (d >= 0) begin
                        errors++;
                        $display("[TB] FAIL string%0d cfg%0d %s cycle %0d: got %b expected %b",
                                 k, cfg, kindName(kind), d, actBit(cfg, kind, d), expBit(cfg, kind, d));
                    end
                end
                checks++;
                if (ccW[cfg] !== 4'(expCount[cfg])) begin
                    errors++;
                    $display("[TB] FAIL string%0d cfg%0d CharCount: got %0d expected %0d", k, cfg, ccW[cfg], expCount[cfg]);
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [STRW-1:0] s;
        int d;
        s = randString($urandom_range(1, 4));
        buildExpect(s, 6);
        startString(s, 0);
        captureRun(expWave[0].size(), 6, randString(MC), 1);
        for (int cfg = 0; cfg < NCFG; cfg++) begin
            for (int kind = 0; kind < 3; kind++) begin
                d = diffAt(cfg, kind);
                checks++;
                if (d >= 0) begin
                    errors++;
                    $display("[TB] FAIL busyIgnore cfg%0d %s cycle %0d: got %b expected %b",
                             cfg, kindName(kind), d, actBit(cfg, kind, d), expBit(cfg, kind, d));
                end
            end
            checks++;
            if (ccW[cfg] !== 4'(expCount[cfg])) begin
                errors++;
                $display("[TB] FAIL busyIgnore cfg%0d CharCount: got %0d expected %0d", cfg, ccW[cfg], expCount[cfg]);
            end
        end
    endtask

    // With Start held, the second string is accepted on the IDLE cycle right after DONE.
    task automatic test_back_to_back();
        logic [STRW-1:0] s1, s2;
        int d;
        s1 = randString($urandom_range(1, 3));
        s2 = randString($urandom_range(1, 3));
        startString(s1, 1);
        for (int r = 0; r < 2; r++) begin
            buildExpect((r == 0) ? s1 : s2, (r == 0) ? 1 : 3);
            if (r == 1) start = 1'b0;
            captureRun(expWave[0].size(), (r == 0) ? 0 : -1, s2, 0);
            for (int cfg = 0; cfg < NCFG; cfg++) begin
                for (int kind = 0; kind < 3; kind++) begin
                    d = diffAt(cfg, kind);
                    checks++;
                    if (d >= 0) begin
                        errors++;
                        $display("[TB] FAIL backToBack%0d cfg%0d %s cycle %0d: got %b expected %b",
                                 r, cfg, kindName(kind), d, actBit(cfg, kind, d), expBit(cfg, kind, d));
                    end
                end
                checks++;
                if (ccW[cfg] !== 4'(expCount[cfg])) begin
                    errors++;
                    $display("[TB] FAIL backToBack%0d cfg%0d CharCount: got %0d expected %0d", r, cfg, ccW[cfg], expCount[cfg]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [STRW-1:0] s;
        int d;
        int idleBad;
        s = '0; s[0 +: CW] = 7'h41; s[CW +: CW] = 7'h42;
        buildExpect(s, 0);
        startString(s, 0);
        captureRun(2 + 5*CD + 1, -1, '0, 0);
        for (int cfg = 0; cfg < NCFG; cfg++) begin
            d = diffAt(cfg, 0);
            checks++;
            if (d >= 0) begin
                errors++;
                $display("[TB] FAIL midReset prefix cfg%0d SendBit cycle %0d: got %b expected %b",
                         cfg, d, actWave[cfg][d], expWave[cfg][d]);
            end
        end
        resetN = 1'b0;
        #1;
        for (int cfg = 0; cfg < NCFG; cfg++) begin
            checks++; if (sendBitW[cfg] !== 1'b1) begin errors++; $display("[TB] FAIL midReset cfg%0d SendBit: got %b expected 1", cfg, sendBitW[cfg]); end
            checks++; if (busyW[cfg] !== 1'b0) begin errors++; $display("[TB] FAIL midReset cfg%0d Busy: got %b expected 0", cfg, busyW[cfg]); end
            checks++; if (ccW[cfg] !== 4'd0) begin errors++; $display("[TB] FAIL midReset cfg%0d CharCount: got %0d expected 0", cfg, ccW[cfg]); end
        end
        @(posedge clk); #1;
        resetN = 1'b1;
        idleBad = 0;
        repeat (60) begin
            @(posedge clk); #1;
            for (int cfg = 0; cfg < NCFG; cfg++) begin
                if (sendBitW[cfg] !== 1'b1 || busyW[cfg] !== 1'b0 || doneW[cfg] !== 1'b0) idleBad++;
            end
        end
        checks++;
        if (idleBad != 0) begin
            errors++;
            $display("[TB] FAIL afterReset idle samples not idle: got %0d expected 0", idleBad);
        end
    endtask

    initial begin
        resetN    = 1'b1;
        start     = 1'b0;
        stringPov = '0;
        test_reset();
        test_strings();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
